mac_psum_accum: RTL and testbench

//  Downstream stage of the dual-int8 mac. Consumes the mac output beat (dv + two

---
 rtl/mac_psum_accum.sv | 92 +++++++++
 tb/tb_mac_psum_accum.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_psum_accum.sv
// mac_psum_accum: sums length-counted runs of mac product pairs with saturation into a small output FIFO
module mac_psum_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W = 24,
  parameter int LEN_W = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEN_W-1:0]   len,
  input  logic               dv,
  input  logic [PROD_W-1:0]  data1,
  input  logic [PROD_W-1:0]  data2,
  output logic               psum_valid,
  input  logic               ready,
  output logic [ACC_W-1:0]   psum1,
  output logic [ACC_W-1:0]   psum2,
  output logic               sat1,
  output logic               sat2,
  output logic               ovf,
  output logic               busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] ONE = 1;
  typedef enum logic {IDLE, ACC} state_t;
  state_t state;
  logic [LEN_W-1:0] cnt, run_len, eff_len;
  logic [ACC_W-1:0] acc1, acc2, nacc1, nacc2;
  logic s1, s2, nsat1, nsat2, idle, push, pop, wr, full, empty;
  logic [ACC_W:0] r1, r2;
  logic [2*ACC_W+1:0] mem [FIFO_DEPTH];
  logic [2*ACC_W+1:0] head;
  logic [AW:0] wp, rp;
  // Returns {clamped, value}; one guard bit is enough to detect overflow of a single add.
  function automatic logic [ACC_W:0] satadd(input logic [ACC_W-1:0] a, input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
    return (s[ACC_W] == s[ACC_W-1]) ? {1'b0, s[ACC_W-1:0]} :
           s[ACC_W] ? {2'b11, {(ACC_W-1){1'b0}}} : {2'b10, {(ACC_W-1){1'b1}}};
  endfunction
  always_comb begin
    idle = state == IDLE;
    eff_len = (len == '0) ? ONE : len;
    r1 = satadd(idle ? '0 : acc1, data1);
    r2 = satadd(idle ? '0 : acc2, data2);
    nacc1 = r1[ACC_W-1:0];
    nacc2 = r2[ACC_W-1:0];
    nsat1 = (!idle & s1) | r1[ACC_W];
    nsat2 = (!idle & s2) | r2[ACC_W];
    push = dv & (idle ? eff_len == ONE : cnt + ONE == run_len);
    empty = wp == rp;
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    pop = !empty & ready;
    wr = push & (!full | pop);
    head = mem[rp[AW-1:0]];
    psum_valid = !empty;
    {psum1, psum2, sat1, sat2} = empty ? '0 : head;
    busy = state == ACC;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      run_len <= '0;
      acc1 <= '0;
      acc2 <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (dv) begin
      acc1 <= nacc1;
      acc2 <= nacc2;
      s1 <= nsat1;
      s2 <= nsat2;
      cnt <= idle ? ONE : cnt + ONE;
      if (idle) run_len <= eff_len;
      state <= push ? IDLE : ACC;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      ovf <= 1'b0;
    end else begin
      wp <= wp + {{AW{1'b0}}, wr};
      rp <= rp + {{AW{1'b0}}, pop};
      if (push & full & !pop) ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= {nacc1, nacc2, nsat1, nsat2};
endmodule

// File: tb/tb_mac_psum_accum.sv
// tb_mac_psum_accum: directed runs checked against a queue-based run/sum model plus literal expectations
module tb_mac_psum_accum;
  localparam int P = 16, A = 24, LW = 10, D = 4;
  localparam int MAXV = 8388607, MINV = -8388608;
  logic clk = 0, rst = 1, dv = 0, ready = 0;
  logic [LW-1:0] len = '0;
  logic [P-1:0] d1 = '0, d2 = '0;
  logic psum_valid, sat1, sat2, ovf, busy;
  logic [A-1:0] psum1, psum2;
  int tests = 0, fails = 0;
  bit chk_en = 0;

  mac_psum_accum #(.PROD_W(P), .ACC_W(A), .LEN_W(LW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .len(len), .dv(dv), .data1(d1), .data2(d2),
    .psum_valid(psum_valid), .ready(ready), .psum1(psum1), .psum2(psum2),
    .sat1(sat1), .sat2(sat2), .ovf(ovf), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  typedef struct {int p1; int p2; bit s1; bit s2;} ent_t;
  ent_t q[$];
  int m_s1, m_s2, m_n, m_len;
  bit m_in = 0, m_sat1, m_sat2, m_ovf = 0, m_pop;

  function automatic int clamp(input int v, inout bit s);
    if (v > MAXV) begin s = 1; return MAXV; end
    if (v < MINV) begin s = 1; return MINV; end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_in = 0;
      m_ovf = 0;
    end else begin
      m_pop = q.size() > 0 && ready;
      if (dv) begin
        if (!m_in) begin
          m_len = (len == 0) ? 1 : int'(len);
          m_s1 = 0; m_s2 = 0; m_n = 0; m_sat1 = 0; m_sat2 = 0; m_in = 1;
        end
        m_s1 = clamp(m_s1 + int'($signed(d1)), m_sat1);
        m_s2 = clamp(m_s2 + int'($signed(d2)), m_sat2);
        m_n++;
        if (m_n == m_len) begin
          m_in = 0;
          if (q.size() < D || m_pop) q.push_back('{m_s1, m_s2, m_sat1, m_sat2});
          else m_ovf = 1;
        end
      end
      if (m_pop) void'(q.pop_front());
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("cmp_valid", int'(psum_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      chk("cmp_psum1", int'($signed(psum1)), q[0].p1);
      chk("cmp_psum2", int'($signed(psum2)), q[0].p2);
      chk("cmp_sat1", int'(sat1), int'(q[0].s1));
      chk("cmp_sat2", int'(sat2), int'(q[0].s2));
    end
    chk("cmp_ovf", int'(ovf), int'(m_ovf));
    chk("cmp_busy", int'(busy), int'(m_in));
  end

  task automatic beat(input int a, input int b, input int l);
    len = LW'(l); d1 = P'(a); d2 = P'(b); dv = 1;
    @(posedge clk); #1;
    dv = 0;
  endtask

  task automatic drain();
    ready = 1;
    repeat (D + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    // basic run of four
    ready = 1;
    repeat (4) beat(16129, -16129, 4);
    chk("t2_valid", int'(psum_valid), 1);
    chk("t2_psum1", int'($signed(psum1)), 64516);
    chk("t2_psum2", int'($signed(psum2)), -64516);
    chk("t2_sat", int'({sat1, sat2}), 0);
    drain();
    // saturation in both directions
    repeat (521) beat(16129, -16129, 521);
    chk("t3_psum1", int'($signed(psum1)), MAXV);
    chk("t3_sat1", int'(sat1), 1);
    chk("t3_psum2", int'($signed(psum2)), MINV);
    chk("t3_sat2", int'(sat2), 1);
    drain();
    // backpressure and drop
    ready = 0;
    for (int k = 1; k <= 5; k++) beat(k, 0, 1);
    chk("t4_ovf", int'(ovf), 1);
    ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_order", int'($signed(psum1)), k);
      @(posedge clk); #1;
    end
    chk("t4_empty", int'(psum_valid), 0);
    chk("t4_ovf_sticky", int'(ovf), 1);
    // gaps and zero length
    beat(10, 0, 3);
    repeat (2) @(posedge clk);
    #1 beat(20, 0, 3);
    repeat (2) @(posedge clk);
    #1 beat(30, 0, 3);
    chk("t5_gap_sum", int'($signed(psum1)), 60);
    drain();
    beat(7, 0, 0);
    chk("t5_len0", int'($signed(psum1)), 7);
    drain();
    // reset mid-traffic
    ready = 0;
    beat(9, 0, 1);
    beat(3, 0, 2);
    rst = 1;
    #1;
    chk("t1_valid", int'(psum_valid), 0);
    chk("t1_psum1", int'(psum1), 0);
    chk("t1_psum2", int'(psum2), 0);
    chk("t1_ovf", int'(ovf), 0);
    chk("t1_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 0;
    // full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) beat(k, 0, 1);
    ready = 1;
    beat(5, 0, 1);
    chk("t6_no_ovf", int'(ovf), 0);
    for (int k = 2; k <= 5; k++) begin
      chk("t6_order", int'($signed(psum1)), k);
      @(posedge clk); #1;
    end
    // reset mid-run discards partial run
    beat(1, 0, 4);
    beat(2, 0, 4);
    chk("t6_busy", int'(busy), 1);
    rst = 1;
    #1 chk("t6_busy_rst", int'(busy), 0);
    @(posedge clk); #1 rst = 0;
    beat(5, 0, 2);
    beat(6, 0, 2);
    chk("t6_psum1", int'($signed(psum1)), 11);
    drain();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
